// File: rtl/decode_bypass_stage_pkg.sv
// Shared definitions for the decode stage with write-back bypass.
// Holds the destination-register select encodings, the immediate-mode
// encodings and the register-file geometry used by the top and rf_bypass.
package decode_bypass_stage_pkg;

  localparam int NUM_REGS = 8;
  localparam int REG_AW   = 3;

  localparam logic [REG_AW-1:0] LINK_REG = 3'd7;

  typedef enum logic [1:0] {
    RD_RT = 2'b00,  // instr[7:5]
    RD_RD = 2'b01,  // instr[4:2]
    RD_RS = 2'b10,  // instr[10:8]
    RD_R7 = 2'b11   // fixed link register
  } regdst_e;

  typedef enum logic [1:0] {
    IMM_S5  = 2'b00,  // instr[4:0]
    IMM_S8  = 2'b01,  // instr[7:0]
    IMM_S11 = 2'b10,  // instr[10:0]
    IMM_BAD = 2'b11   // illegal, forces zero and raises err
  } imm_mode_e;

endpackage

// File: rtl/decode_bypass_stage_rf_bypass.sv
// rf_bypass: 8-entry register file, two combinational read ports, one
// write port. With BYPASS != 0 a same-cycle write to a read address is
// forwarded to that read port.
// Ports: clk, rst (async active-low), we/waddr/wdata (write port),
//        raddr1/rdata1, raddr2/rdata2 (read ports).
module rf_bypass
  import decode_bypass_stage_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = regs[raddr1];
    rdata2 = regs[raddr2];
    if (BYPASS != 0 && we && waddr == raddr1) rdata1 = wdata;
    if (BYPASS != 0 && we && waddr == raddr2) rdata2 = wdata;
  end

endmodule

// File: rtl/decode_bypass_stage.sv
// decode_bypass_stage: instruction decode with register read, immediate
// extension, load-use hazard detection and the ID/EX pipeline register.
// Ports: clk, rst (async active-low); IF/ID instruction, PC+2, valid;
//        control bundle and decoded control bits; flush / stall_ext;
//        MEM/WB write-back port; ID/EX outputs; stall_out and err status.
module decode_bypass_stage
  import decode_bypass_stage_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 12,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       instr_IFID,
  input  logic [DATA_W-1:0] PC2_IFID,
  input  logic              valid_IFID,
  input  logic [CTRL_W-1:0] ctrl,
  input  logic              RegWrite,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [1:0]        RegDst,
  input  logic [1:0]        size,
  input  logic              zeroEx,
  input  logic              flush,
  input  logic              stall_ext,
  input  logic [2:0]        WrR_MEMWB,
  input  logic [DATA_W-1:0] writeData,
  input  logic              RegWrite_MEMWB,
  output logic [DATA_W-1:0] PC2_IDEX,
  output logic [DATA_W-1:0] Rd1_IDEX,
  output logic [DATA_W-1:0] Rd2_IDEX,
  output logic [DATA_W-1:0] Imm_IDEX,
  output logic [CTRL_W-1:0] ctrl_IDEX,
  output logic              RegWrite_IDEX,
  output logic              MemWrite_IDEX,
  output logic              MemRead_IDEX,
  output logic              valid_IDEX,
  output logic [2:0]        WrR_IDEX,
  output logic [2:0]        Rs_IDEX,
  output logic [2:0]        Rt_IDEX,
  output logic              stall_out,
  output logic              err
);

  function automatic logic signed [DATA_W-1:0] ext_imm(
    input logic [15:0] ins,
    input logic [1:0]  sz,
    input logic        zx
  );
    logic signed [DATA_W-1:0] r;
    r = '0;
    case (imm_mode_e'(sz))
      IMM_S5:  r = zx ? DATA_W'(ins[4:0])  : DATA_W'($signed(ins[4:0]));
      IMM_S8:  r = zx ? DATA_W'(ins[7:0])  : DATA_W'($signed(ins[7:0]));
      IMM_S11: r = zx ? DATA_W'(ins[10:0]) : DATA_W'($signed(ins[10:0]));
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [REG_AW-1:0]        rs_p0, rt_p0, wrr_p0;
  logic [DATA_W-1:0]        rd1_p0, rd2_p0;
  logic signed [DATA_W-1:0] imm_p0;
  logic                     vld_p0;
  logic                     unused_opcode;

  assign unused_opcode = ^instr_IFID[15:11];

  assign rs_p0 = instr_IFID[10:8];
  assign rt_p0 = instr_IFID[7:5];

  rf_bypass #(
    .DATA_W (DATA_W),
    .BYPASS (BYPASS)
  ) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (RegWrite_MEMWB),
    .waddr  (WrR_MEMWB),
    .wdata  (writeData),
    .raddr1 (rs_p0),
    .raddr2 (rt_p0),
    .rdata1 (rd1_p0),
    .rdata2 (rd2_p0)
  );

  always_comb begin
    wrr_p0 = rt_p0;
    case (regdst_e'(RegDst))
      RD_RT:   wrr_p0 = instr_IFID[7:5];
      RD_RD:   wrr_p0 = instr_IFID[4:2];
      RD_RS:   wrr_p0 = instr_IFID[10:8];
      default: wrr_p0 = LINK_REG;
    endcase
  end

  assign imm_p0 = ext_imm(instr_IFID, size, zeroEx);
  assign err    = valid_IFID && (imm_mode_e'(size) == IMM_BAD);

  // A load in ID/EX whose destination feeds this instruction must wait a cycle.
  assign stall_out = valid_IDEX && MemRead_IDEX && RegWrite_IDEX && valid_IFID &&
                     !flush && (WrR_IDEX == rs_p0 || WrR_IDEX == rt_p0);

  assign vld_p0 = valid_IFID && !flush && !stall_out;

  // ---- ID/EX boundary ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PC2_IDEX      <= '0;
      Rd1_IDEX      <= '0;
      Rd2_IDEX      <= '0;
      Imm_IDEX      <= '0;
      ctrl_IDEX     <= '0;
      WrR_IDEX      <= '0;
      Rs_IDEX       <= '0;
      Rt_IDEX       <= '0;
      valid_IDEX    <= 1'b0;
      RegWrite_IDEX <= 1'b0;
      MemWrite_IDEX <= 1'b0;
      MemRead_IDEX  <= 1'b0;
    end else if (stall_ext && !flush) begin
      // Held operands still pick up a write-back that lands during the hold.
      if (RegWrite_MEMWB && WrR_MEMWB == Rs_IDEX) Rd1_IDEX <= writeData;
      if (RegWrite_MEMWB && WrR_MEMWB == Rt_IDEX) Rd2_IDEX <= writeData;
    end else begin
      // Load and bubble share the data path; only the control bits differ.
      PC2_IDEX      <= PC2_IFID;
      Rd1_IDEX      <= rd1_p0;
      Rd2_IDEX      <= rd2_p0;
      Imm_IDEX      <= imm_p0;
      ctrl_IDEX     <= ctrl;
      WrR_IDEX      <= wrr_p0;
      Rs_IDEX       <= rs_p0;
      Rt_IDEX       <= rt_p0;
      valid_IDEX    <= vld_p0;
      RegWrite_IDEX <= vld_p0 && RegWrite;
      MemWrite_IDEX <= vld_p0 && MemWrite;
      MemRead_IDEX  <= vld_p0 && MemRead;
    end
  end

endmodule

// File: tb/tb_decode_bypass_stage.sv
module tb_decode_bypass_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr_IFID, PC2_IFID, writeData;
  logic        valid_IFID, RegWrite, MemWrite, MemRead, zeroEx;
  logic [11:0] ctrl;
  logic [1:0]  RegDst, size;
  logic        flush, stall_ext, RegWrite_MEMWB;
  logic [2:0]  WrR_MEMWB;
  logic [15:0] PC2_IDEX, Rd1_IDEX, Rd2_IDEX, Imm_IDEX;
  logic [11:0] ctrl_IDEX;
  logic        RegWrite_IDEX, MemWrite_IDEX, MemRead_IDEX, valid_IDEX;
  logic [2:0]  WrR_IDEX, Rs_IDEX, Rt_IDEX;
  logic        stall_out, err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_bypass_stage #(.DATA_W(16), .CTRL_W(12), .BYPASS(1)) dut (
    .clk(clk), .rst(rst),
    .instr_IFID(instr_IFID), .PC2_IFID(PC2_IFID), .valid_IFID(valid_IFID),
    .ctrl(ctrl), .RegWrite(RegWrite), .MemWrite(MemWrite), .MemRead(MemRead),
    .RegDst(RegDst), .size(size), .zeroEx(zeroEx),
    .flush(flush), .stall_ext(stall_ext),
    .WrR_MEMWB(WrR_MEMWB), .writeData(writeData), .RegWrite_MEMWB(RegWrite_MEMWB),
    .PC2_IDEX(PC2_IDEX), .Rd1_IDEX(Rd1_IDEX), .Rd2_IDEX(Rd2_IDEX), .Imm_IDEX(Imm_IDEX),
    .ctrl_IDEX(ctrl_IDEX), .RegWrite_IDEX(RegWrite_IDEX), .MemWrite_IDEX(MemWrite_IDEX),
    .MemRead_IDEX(MemRead_IDEX), .valid_IDEX(valid_IDEX),
    .WrR_IDEX(WrR_IDEX), .Rs_IDEX(Rs_IDEX), .Rt_IDEX(Rt_IDEX),
    .stall_out(stall_out), .err(err)
  );

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc2;
    logic        vin;
    logic [1:0]  regdst;
    logic [1:0]  sz;
    logic        zx;
    logic        rw;
    logic        mw;
    logic        fl;
    logic [15:0] e_rd1;
    logic [15:0] e_rd2;
    logic [15:0] e_imm;
    logic [2:0]  e_wrr;
    logic        e_vld;
    logic        e_rw;
    logic        e_mw;
    logic        e_err;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr_IFID = '0; PC2_IFID = '0; valid_IFID = 1'b0; ctrl = '0;
    RegWrite = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
    RegDst = 2'b00; size = 2'b00; zeroEx = 1'b0;
    flush = 1'b0; stall_ext = 1'b0;
    WrR_MEMWB = '0; writeData = '0; RegWrite_MEMWB = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{16'h014C, 16'h0100, 1'b1, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0,
               16'h1111, 16'h2222, 16'h000C, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{16'h07A7, 16'h0102, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0,
               16'h7777, 16'h5555, 16'hFFA7, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{16'h07A7, 16'h0104, 1'b1, 2'b10, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0,
               16'h7777, 16'h5555, 16'h00A7, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{16'hF400, 16'h0106, 1'b1, 2'b11, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0,
               16'h4444, 16'h0000, 16'hFC00, 3'd7, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{16'hF400, 16'h0108, 1'b1, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0,
               16'h4444, 16'h0000, 16'h0400, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{16'h0280, 16'h010A, 1'b1, 2'b00, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0,
               16'h2222, 16'h4444, 16'h0000, 3'd4, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{16'h0360, 16'h010C, 1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0,
               16'h3333, 16'h3333, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{16'h0124, 16'h010E, 1'b1, 2'b01, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1,
               16'h1111, 16'h1111, 16'h0004, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{16'h0000, 16'h0110, 1'b0, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0,
               16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state
    rst = 1'b0;
    idle_inputs();
    valid_IFID = 1'b1; RegWrite = 1'b1; PC2_IFID = 16'h5A5A;
    tick(); tick();
    chk("rst_valid", valid_IDEX, 0);
    chk("rst_regwrite", RegWrite_IDEX, 0);
    chk("rst_pc2", PC2_IDEX, 0);
    chk("rst_stall", stall_out, 0);
    idle_inputs();
    rst = 1'b1;
    tick();

    // Preload R[i] = 0x1111*i
    for (int i = 0; i < 8; i++) begin
      RegWrite_MEMWB = 1'b1;
      WrR_MEMWB = 3'(i);
      writeData = 16'(32'h1111 * i);
      tick();
    end
    RegWrite_MEMWB = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 9; i++) begin
      instr_IFID = tbl[i].instr; PC2_IFID = tbl[i].pc2; valid_IFID = tbl[i].vin;
      RegDst = tbl[i].regdst; size = tbl[i].sz; zeroEx = tbl[i].zx;
      RegWrite = tbl[i].rw; MemWrite = tbl[i].mw; MemRead = 1'b0; flush = tbl[i].fl;
      ctrl = 12'(3 * i + 1);
      #1;
      chk($sformatf("v%0d_err", i), err, tbl[i].e_err);
      tick();
      chk($sformatf("v%0d_rd1", i), Rd1_IDEX, tbl[i].e_rd1);
      chk($sformatf("v%0d_rd2", i), Rd2_IDEX, tbl[i].e_rd2);
      chk($sformatf("v%0d_imm", i), Imm_IDEX, tbl[i].e_imm);
      chk($sformatf("v%0d_wrr", i), WrR_IDEX, tbl[i].e_wrr);
      chk($sformatf("v%0d_pc2", i), PC2_IDEX, tbl[i].pc2);
      chk($sformatf("v%0d_ctrl", i), ctrl_IDEX, 12'(3 * i + 1));
      chk($sformatf("v%0d_vld", i), valid_IDEX, tbl[i].e_vld);
      chk($sformatf("v%0d_rw", i), RegWrite_IDEX, tbl[i].e_rw);
      chk($sformatf("v%0d_mw", i), MemWrite_IDEX, tbl[i].e_mw);
    end
    idle_inputs();

    // Same-cycle write-back bypass into R3
    instr_IFID = 16'h0300; valid_IFID = 1'b1;
    RegWrite_MEMWB = 1'b1; WrR_MEMWB = 3'd3; writeData = 16'hBEEF;
    tick();
    chk("byp_rd1", Rd1_IDEX, 16'hBEEF);
    chk("byp_rs", Rs_IDEX, 3);
    RegWrite_MEMWB = 1'b0;
    tick();
    chk("byp_stored", Rd1_IDEX, 16'hBEEF);

    // Load-use stall
    idle_inputs();
    instr_IFID = 16'h0140; valid_IFID = 1'b1; MemRead = 1'b1; RegWrite = 1'b1;
    tick();
    chk("lu_load_wrr", WrR_IDEX, 2);
    chk("lu_load_mr", MemRead_IDEX, 1);
    instr_IFID = 16'h0340; MemRead = 1'b0; PC2_IFID = 16'h0200;
    #1;
    chk("lu_stall_on", stall_out, 1);
    tick();
    chk("lu_bubble_vld", valid_IDEX, 0);
    chk("lu_bubble_rw", RegWrite_IDEX, 0);
    #1;
    chk("lu_stall_off", stall_out, 0);
    tick();
    chk("lu_load_vld", valid_IDEX, 1);
    chk("lu_load_rs", Rs_IDEX, 3);
    chk("lu_load_pc2", PC2_IDEX, 16'h0200);

    // Hold with write-back refresh of Rd1
    idle_inputs();
    instr_IFID = 16'h0500; PC2_IFID = 16'h1234; valid_IFID = 1'b1; RegWrite = 1'b1;
    tick();
    chk("hold_pre_rd1", Rd1_IDEX, 16'h5555);
    stall_ext = 1'b1; PC2_IFID = 16'hDEAD; instr_IFID = 16'h0100;
    RegWrite_MEMWB = 1'b1; WrR_MEMWB = 3'd5; writeData = 16'h0042;
    for (int c = 0; c < 3; c++) begin
      tick();
      RegWrite_MEMWB = 1'b0;
      chk($sformatf("hold%0d_rd1", c), Rd1_IDEX, 16'h0042);
      chk($sformatf("hold%0d_pc2", c), PC2_IDEX, 16'h1234);
      chk($sformatf("hold%0d_vld", c), valid_IDEX, 1);
      chk($sformatf("hold%0d_rs", c), Rs_IDEX, 5);
    end
    idle_inputs();

    // Flush beats stall_ext
    instr_IFID = 16'h0100; PC2_IFID = 16'h0300; valid_IFID = 1'b1; MemWrite = 1'b1;
    tick();
    chk("fl_pre_mw", MemWrite_IDEX, 1);
    flush = 1'b1; stall_ext = 1'b1;
    tick();
    chk("fl_vld", valid_IDEX, 0);
    chk("fl_mw", MemWrite_IDEX, 0);
    idle_inputs();

    // Asynchronous reset between edges, then normal first edge
    instr_IFID = 16'h0100; PC2_IFID = 16'h0400; valid_IFID = 1'b1; RegWrite = 1'b1;
    tick();
    chk("ar_pre_rw", RegWrite_IDEX, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_rw", RegWrite_IDEX, 0);
    chk("ar_vld", valid_IDEX, 0);
    chk("ar_pc2", PC2_IDEX, 0);
    chk("ar_rd1", Rd1_IDEX, 0);
    chk("ar_stall", stall_out, 0);
    #2;
    rst = 1'b1;
    tick();
    chk("ar_post_vld", valid_IDEX, 1);
    chk("ar_post_pc2", PC2_IDEX, 16'h0400);
    chk("ar_post_rd1", Rd1_IDEX, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
